pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS core; sequences the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Merges stall requests from ID, EX and the MEM-stage bus handshake into a 6-bit stall vector.
- Injects flushes with a redirect PC and defers a flush that arrives while a memory access is in flight.
- Times out hung bus accesses and counts stall cycles for performance monitoring.

Parameters:
- PC_W, 32, width of flush_pc_in / flush_pc.
- TIMEOUT, 16, maximum MEM-wait cycles before bus_err (≥2).
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- stallreq_id  in  1  ID-stage stall request (load-use hazard).
- stallreq_ex  in  1  EX-stage stall request (multi-cycle op).
- mem_req  in  1  MEM stage has an access in progress this cycle.
- mem_ack  in  1  bus completes the access this cycle.
- flush_req  in  1  exception/redirect request.
- flush_pc_in  in  PC_W  redirect target paired with flush_req.
- stall  out  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB (always 0).
- flush  out  1  clear all pipeline registers this cycle.
- flush_pc  out  PC_W  redirect PC, valid when flush=1.
- bus_err  out  1  one-cycle pulse on MEM timeout.
- stall_cnt  out  CNT_W  saturating count of cycles with stall≠0.

Behaviour:
- Reset (rst=0, async):
  - state=RUN, timer=0, pend_pc=0, bus_err=0, stall_cnt=0.
  - stall=0, flush=0, flush_pc=0.
- States: RUN, MWAIT, MWAIT_FP (wait with flush pending), FLUSH.
- stall, flush and flush_pc are combinational from state and inputs; bus_err, stall_cnt, pend_pc and timer are registered.
- Stall encodings:
  - MEM=6'b011111, EX=6'b001111, ID=6'b000111, none=0.
  - Priority: flush > MEM > EX > ID.
- Stage i stalled with stage i+1 not stalled means the consumer inserts a bubble. The controller only drives the vector.
- RUN:
  - flush_req=1: flush=1, flush_pc=flush_pc_in, stall=0, stay in RUN.
  - Else if mem_req & !mem_ack: stall=MEM, go to MWAIT, timer←1.
  - Else stall follows the EX/ID priority.
  - mem_req & mem_ack in the same cycle completes with zero wait; no stall.
- MWAIT:
  - stall=MEM, flush=0. The in-flight access is never cancelled.
  - mem_ack=1: stall=MEM this cycle, go to RUN.
  - flush_req=1 without ack: pend_pc←flush_pc_in, go to MWAIT_FP.
  - flush_req & mem_ack together: pend_pc←flush_pc_in, go to FLUSH.
  - timer==TIMEOUT with no ack: bus_err←1 next cycle, go to RUN, timer←0.
  - Otherwise timer+1.
- MWAIT_FP:
  - Same stall and timer rules as MWAIT. Further flush_req is ignored; the first pend_pc is kept.
  - On mem_ack or timeout go to FLUSH. On timeout, bus_err also pulses.
- FLUSH (exactly one cycle): flush=1, flush_pc=pend_pc, stall=0, go to RUN. Inputs are ignored this cycle.
- stall_cnt: +1 on every cycle with stall≠0; holds at all-ones. Not cleared by flush.
- bus_err is high for exactly one cycle per timeout.
- Reset asserted mid-wait abandons the pending flush and returns all outputs to their reset values immediately.

Decomposition:
- Shared package/`define header: stall-vector encodings STALL_NONE/ID/EX/MEM, state encodings (2-bit), PC_W default.
- Sub-module wait_timer: counter with load, increment and expired flag. Instantiated once for the MEM timeout.
- FSM and stall-priority logic stay in pipe_ctrl.

Test Plan:
1. Reset then idle with all requests 0 → stall=0, flush=0, stall_cnt=0; async: rst low mid-cycle clears outputs before the next edge.
2. stallreq_id=1 for 2 cycles, then stallreq_ex=1 together with stallreq_id=1 for 1 cycle → stall=000111 ×2, then 001111; stall_cnt=3.
3. mem_req=1 with mem_ack delayed 3 cycles → stall=011111 for 4 cycles (entry + 3); returns to RUN; stall_cnt +4.
4. flush_req=1, flush_pc_in=0xBFC00380 in RUN → flush=1, flush_pc=0xBFC00380, stall=0 in the same cycle.
5. In MWAIT, flush_req with 0x80000180, then mem_ack 2 cycles later → stall=011111 until ack; next cycle flush=1, flush_pc=0x80000180.
6. mem_req held with no ack, TIMEOUT=16 → stall held 17 cycles, bus_err high exactly 1 cycle, then stall=0; a pending flush is issued on the following cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: stall vectors and FSM states.
package pipe_ctrl_pkg;

  localparam int PC_W_DEF = 32;

  // bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MWAIT    = 2'd1,
    MWAIT_FP = 2'd2,
    FLUSH    = 2'd3
  } state_t;

endpackage

// File: rtl/pipe_ctrl_wait_timer.sv
// Up-counter with clear, load-to-one and increment; flags when it reaches LIMIT.
module pipe_ctrl_wait_timer #(
  parameter int W     = 5,
  parameter int LIMIT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         expired
);

  localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (load)
      count <= {{(W-1){1'b0}}, 1'b1};
    else if (inc)
      count <= count + 1'b1;
  end

  assign expired = (count == LIMIT_V);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stall requests, issues/defers flushes, times out
// hung MEM accesses and counts stalled cycles.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             flush_req,
  input  logic [PC_W-1:0]  flush_pc_in,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [PC_W-1:0]  flush_pc,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pend_pc;
  logic            pend_load;
  logic            timeout;
  logic            t_clr, t_load, t_inc, t_expired;
  logic [TW-1:0]   t_count;

  pipe_ctrl_wait_timer #(
    .W     (TW),
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (t_clr),
    .load    (t_load),
    .inc     (t_inc),
    .count   (t_count),
    .expired (t_expired)
  );

  always_comb begin
    state_nxt = state;
    stall     = STALL_NONE;
    flush     = 1'b0;
    flush_pc  = '0;
    t_clr     = 1'b0;
    t_load    = 1'b0;
    t_inc     = 1'b0;
    pend_load = 1'b0;
    timeout   = 1'b0;
    case (state)
      RUN: begin
        if (flush_req) begin
          flush    = 1'b1;
          flush_pc = flush_pc_in;
        end else if (mem_req && !mem_ack) begin
          stall     = STALL_MEM;
          t_load    = 1'b1;
          state_nxt = MWAIT;
        end else if (stallreq_ex) begin
          stall = STALL_EX;
        end else if (stallreq_id) begin
          stall = STALL_ID;
        end
      end
      // A flush seen while waiting is latched and issued once the access ends
      MWAIT: begin
        stall     = STALL_MEM;
        pend_load = flush_req;
        if (mem_ack || t_expired) begin
          t_clr     = 1'b1;
          timeout   = !mem_ack;
          state_nxt = flush_req ? FLUSH : RUN;
        end else begin
          t_inc     = 1'b1;
          state_nxt = flush_req ? MWAIT_FP : MWAIT;
        end
      end
      MWAIT_FP: begin
        stall = STALL_MEM;
        if (mem_ack || t_expired) begin
          t_clr     = 1'b1;
          timeout   = !mem_ack;
          state_nxt = FLUSH;
        end else begin
          t_inc = 1'b1;
        end
      end
      FLUSH: begin
        flush     = 1'b1;
        flush_pc  = pend_pc;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      pend_pc   <= '0;
      bus_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bus_err <= timeout;
      if (pend_load)
        pend_pc <= flush_pc_in;
      if ((stall != STALL_NONE) && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
